desc_fifo: RTL and testbench

- Descriptor queue between the DMA slave register file (producer) and the DMA master (consumer).
- Each entry holds one transfer descriptor {src_addr, dest_addr, data_size}, pushed by the slave's wr_en pulse and popped by the master when it starts a transfer.
- Provides registered full/empty flags, an occupancy count, and per-operation ack/error strobes.
- op_clear from the slave flushes the queue.

---
 rtl/desc_fifo.sv | 124 ++++++++++++
 tb/tb_desc_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/desc_fifo.sv
// desc_fifo: descriptor queue between the DMA slave register file and the DMA master.
// Optional `DESC_FIFO_THRESH_EN adds almost_full / almost_empty outputs.
module desc_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_clear,
    input  logic          wr_en,
    input  logic [31:0]   din_src,
    input  logic [31:0]   din_dest,
    input  logic [31:0]   din_size,
    input  logic          rd_en,
    output logic [31:0]   dout_src,
    output logic [31:0]   dout_dest,
    output logic [31:0]   dout_size,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   data_count,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
`ifdef DESC_FIFO_THRESH_EN
    ,
    output logic          almost_full,
    output logic          almost_empty
`endif
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        INIT,
        NO_OP,
        WRITE,
        WR_ERROR,
        READ,
        RD_ERROR
    } state_e;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dest;
        logic [31:0] size;
    } desc_t;

    desc_t         mem_q [DEPTH];
    desc_t         dout_q;
    state_e        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_c;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Accepted push only; reset and flush never write the array.
    always_comb begin
        push_c = 1'b0;
        if (!reset && !op_clear && wr_en && !full) begin
            push_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{src: din_src, dest: din_dest, size: din_size};
        end
    end

    // State names the operation taken on the most recent edge; write beats read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else if (op_clear) begin
            state_q  <= NO_OP;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else if (wr_en) begin
            if (!full) begin
                state_q  <= WRITE;
                wr_ptr_q <= wr_ptr_q + AW'(1);
                count_q  <= count_q + CW'(1);
            end else begin
                state_q  <= WR_ERROR;
            end
        end else if (rd_en) begin
            if (!empty) begin
                state_q  <= READ;
                dout_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q  <= count_q - CW'(1);
            end else begin
                state_q  <= RD_ERROR;
            end
        end else begin
            state_q <= NO_OP;
        end
    end

    assign wr_ack     = (state_q == WRITE);
    assign wr_err     = (state_q == WR_ERROR);
    assign rd_ack     = (state_q == READ);
    assign rd_err     = (state_q == RD_ERROR);
    assign data_count = count_q;
    assign dout_src   = dout_q.src;
    assign dout_dest  = dout_q.dest;
    assign dout_size  = dout_q.size;

`ifdef DESC_FIFO_THRESH_EN
    assign almost_full  = (count_q >= CW'(DEPTH - 1));
    assign almost_empty = (count_q <= CW'(1));
`endif

endmodule

// File: tb/tb_desc_fifo.sv
// Randomized and directed bench for desc_fifo against a queue-based reference model.
module tb_desc_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dest;
        logic [31:0] size;
    } desc_t;

    logic        clk = 1'b0;
    logic        reset, op_clear, wr_en, rd_en;
    logic [31:0] din_src, din_dest, din_size;
    logic [31:0] dout_src, dout_dest, dout_size;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic [AW:0] data_count;
`ifdef DESC_FIFO_THRESH_EN
    logic        almost_full, almost_empty;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    desc_t q[$];
    desc_t exp_dout;
    logic  exp_wack, exp_werr, exp_rack, exp_rerr;

    desc_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .op_clear(op_clear),
        .wr_en(wr_en), .din_src(din_src), .din_dest(din_dest), .din_size(din_size),
        .rd_en(rd_en), .dout_src(dout_src), .dout_dest(dout_dest), .dout_size(dout_size),
        .full(full), .empty(empty), .data_count(data_count),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
`ifdef DESC_FIFO_THRESH_EN
        , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("data_count", 32'(data_count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("dout_src", dout_src, exp_dout.src);
        check("dout_dest", dout_dest, exp_dout.dest);
        check("dout_size", dout_size, exp_dout.size);
        check("wr_ack", 32'(wr_ack), 32'(exp_wack));
        check("wr_err", 32'(wr_err), 32'(exp_werr));
        check("rd_ack", 32'(rd_ack), 32'(exp_rack));
        check("rd_err", 32'(rd_err), 32'(exp_rerr));
`ifdef DESC_FIFO_THRESH_EN
        check("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 1));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= 1));
`endif
    endtask

    // One clock: drive, take the edge, advance the model, compare.
    task automatic step(input logic rst, input logic clr, input logic w, input logic r,
                        input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
        desc_t nd;
        reset = rst; op_clear = clr; wr_en = w; rd_en = r;
        din_src = s; din_dest = d; din_size = z;
        @(posedge clk);
        #1;
        exp_wack = 1'b0; exp_werr = 1'b0; exp_rack = 1'b0; exp_rerr = 1'b0;
        if (rst || clr) begin
            q.delete();
            exp_dout = '0;
        end else if (w) begin
            if (q.size() < DEPTH) begin
                nd = '{src: s, dest: d, size: z};
                q.push_back(nd);
                exp_wack = 1'b1;
            end else begin
                exp_werr = 1'b1;
            end
        end else if (r) begin
            if (q.size() > 0) begin
                exp_dout = q.pop_front();
                exp_rack = 1'b1;
            end else begin
                exp_rerr = 1'b1;
            end
        end
        reset = 1'b0; op_clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_all();
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
        step(1'b0, 1'b0, 1'b1, 1'b0, s, d, z);
    endtask

    task automatic pop();
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; op_clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        din_src = '0; din_dest = '0; din_size = '0;
        exp_dout = '0;
        exp_wack = 1'b0; exp_werr = 1'b0; exp_rack = 1'b0; exp_rerr = 1'b0;

        // Reset then idle.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) idle();

        // Single push and pop.
        push(32'h100, 32'h200, 32'h4);
        pop();
        check("single_dout_src", dout_src, 32'h100);
        idle();

        // Overfill, drain, underflow.
        for (int i = 0; i < 9; i++) push(32'(i), 32'(i + 100), 32'(i + 1));
        check("full_after_9", 32'(full), 32'h1);
        for (int i = 0; i < 8; i++) pop();
        pop();
        check("src_hold_after_rd_err", dout_src, 32'h7);

        // Pointer wrap.
        for (int i = 0; i < 5; i++) push(32'(16'h50 + i), $urandom, $urandom);
        for (int i = 0; i < 5; i++) pop();
        for (int i = 0; i < 6; i++) push(32'(16'h60 + i), $urandom, $urandom);
        for (int i = 0; i < 6; i++) pop();

        // Simultaneous write and read at count 3.
        for (int i = 0; i < 3; i++) push($urandom, $urandom, $urandom);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA, 32'hBBBB, 32'hCCCC);
        check("wr_rd_count", 32'(data_count), 32'h4);

        // Flush with op_clear; new data must come back, not stale entries.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        push(32'hDEAD, 32'hBEEF, 32'h10);
        pop();
        check("post_clear_src", dout_src, 32'hDEAD);

        // Reset in the same edge as a read request.
        push(32'h1234, 32'h5678, 32'h9);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        idle();

        // Random traffic with rare flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) != 0), $urandom, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
